// File: rtl/sb_umi_pkg.sv
// rtl/sb_umi_pkg.sv - shared UMI widths and packed packet layout
//
// Purpose: default UMI field widths and the packed packet typedef used by
//          the elastic FIFO and anything that stores whole UMI packets.
// Ports:   none (package).
package sb_umi_pkg;

   localparam int UMI_DW = 256;
   localparam int UMI_AW = 64;
   localparam int UMI_CW = 32;

   // First field is the MSB end: cmd sits in the LSBs, data in the MSBs.
   typedef struct packed {
      logic [UMI_DW-1:0] data;
      logic [UMI_AW-1:0] srcaddr;
      logic [UMI_AW-1:0] dstaddr;
      logic [UMI_CW-1:0] cmd;
   } umi_packet_t;

   function automatic int umi_pkt_width(input int dw, input int aw, input int cw);
      return cw + 2 * aw + dw;
   endfunction

endpackage

// File: rtl/umi_elastic_fifo_mem.sv
// rtl/umi_elastic_fifo_mem.sv - DEPTH x packet register array, 1 write / 1 async read
//
// Purpose: packet storage for umi_elastic_fifo. Contents are deliberately
//          not reset; validity is tracked by the FIFO pointers.
// Ports:   clk            - write clock
//          we/waddr/wdata - synchronous write port
//          raddr/rdata    - asynchronous (combinational) read port
module umi_elastic_fifo_mem #(
   parameter int PW    = 416,
   parameter int DEPTH = 4,
   parameter int ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDRW-1:0] waddr,
   input  logic [PW-1:0]    wdata,
   input  logic [ADDRW-1:0] raddr,
   output logic [PW-1:0]    rdata
);

   logic [PW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/umi_elastic_fifo.sv
// rtl/umi_elastic_fifo.sv - UMI packet elastic FIFO with optional empty bypass
//
// Purpose: DEPTH-entry FIFO for UMI packets (cmd/dstaddr/srcaddr/data).
//          Optional macro UMI_ELASTIC_FIFO_BYPASS_EN: when the FIFO is empty
//          the input packet is presented combinationally at the output and
//          is not stored if it is consumed in the same cycle.
// Ports:   clk, nreset             - clock, async active-low reset
//          umi_in_*                - upstream packet, valid/ready handshake
//          umi_out_*               - head packet, valid/ready handshake
//          level, full, empty      - occupancy status
module umi_elastic_fifo
   import sb_umi_pkg::*;
#(
   parameter int DW    = UMI_DW,
   parameter int AW    = UMI_AW,
   parameter int CW    = UMI_CW,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     umi_in_valid,
   input  logic [CW-1:0]            umi_in_cmd,
   input  logic [AW-1:0]            umi_in_dstaddr,
   input  logic [AW-1:0]            umi_in_srcaddr,
   input  logic [DW-1:0]            umi_in_data,
   output logic                     umi_in_ready,
   output logic                     umi_out_valid,
   output logic [CW-1:0]            umi_out_cmd,
   output logic [AW-1:0]            umi_out_dstaddr,
   output logic [AW-1:0]            umi_out_srcaddr,
   output logic [DW-1:0]            umi_out_data,
   input  logic                     umi_out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW    = umi_pkt_width(DW, AW, CW);
   localparam int ADDRW = $clog2(DEPTH);
   localparam int PTRW  = ADDRW + 1;
   localparam logic [PTRW-1:0] PTR_ONE = 1;
   localparam logic [PTRW-1:0] PTR_MSB = {1'b1, {ADDRW{1'b0}}};

   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   in_pkt, rd_data, out_pkt;
   logic            bypass, push, pop;

   assign in_pkt = {umi_in_data, umi_in_srcaddr, umi_in_dstaddr, umi_in_cmd};

   // Flags come from registered pointers only, so in_ready never depends
   // on out_ready.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);
   assign level        = wr_ptr_q - rd_ptr_q;
   assign umi_in_ready = !full;

`ifdef UMI_ELASTIC_FIFO_BYPASS_EN
   // nreset gate keeps out_valid low while reset is held.
   assign bypass = empty & umi_in_valid & nreset;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed packet consumed this cycle must not also be stored.
   assign push = umi_in_valid & umi_in_ready & ~(bypass & umi_out_ready);
   assign pop  = !empty & umi_out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   umi_elastic_fifo_mem #(
      .PW    (PW),
      .DEPTH (DEPTH),
      .ADDRW (ADDRW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q[ADDRW-1:0]),
      .wdata (in_pkt),
      .raddr (rd_ptr_q[ADDRW-1:0]),
      .rdata (rd_data)
   );

   // Payload is forced to zero whenever out_valid is low.
   always_comb begin
      out_pkt = '0;
      if (!empty)      out_pkt = rd_data;
      else if (bypass) out_pkt = in_pkt;
   end

   assign umi_out_valid   = !empty | bypass;
   assign umi_out_cmd     = out_pkt[CW-1:0];
   assign umi_out_dstaddr = out_pkt[CW+AW-1:CW];
   assign umi_out_srcaddr = out_pkt[CW+2*AW-1:CW+AW];
   assign umi_out_data    = out_pkt[PW-1:CW+2*AW];

endmodule

// File: tb/tb_umi_elastic_fifo.sv
// tb/tb_umi_elastic_fifo.sv - self-checking bench for umi_elastic_fifo
module tb_umi_elastic_fifo;
   import sb_umi_pkg::*;

   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              nreset;
   logic              umi_in_valid;
   logic [UMI_CW-1:0] umi_in_cmd;
   logic [UMI_AW-1:0] umi_in_dstaddr;
   logic [UMI_AW-1:0] umi_in_srcaddr;
   logic [UMI_DW-1:0] umi_in_data;
   logic              umi_in_ready;
   logic              umi_out_valid;
   logic [UMI_CW-1:0] umi_out_cmd;
   logic [UMI_AW-1:0] umi_out_dstaddr;
   logic [UMI_AW-1:0] umi_out_srcaddr;
   logic [UMI_DW-1:0] umi_out_data;
   logic              umi_out_ready;
   logic [2:0]        level;
   logic              full;
   logic              empty;

   int tests_run    = 0;
   int tests_failed = 0;
   umi_packet_t sb[$];

   umi_elastic_fifo #(.DW(UMI_DW), .AW(UMI_AW), .CW(UMI_CW), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .umi_in_valid    (umi_in_valid),
      .umi_in_cmd      (umi_in_cmd),
      .umi_in_dstaddr  (umi_in_dstaddr),
      .umi_in_srcaddr  (umi_in_srcaddr),
      .umi_in_data     (umi_in_data),
      .umi_in_ready    (umi_in_ready),
      .umi_out_valid   (umi_out_valid),
      .umi_out_cmd     (umi_out_cmd),
      .umi_out_dstaddr (umi_out_dstaddr),
      .umi_out_srcaddr (umi_out_srcaddr),
      .umi_out_data    (umi_out_data),
      .umi_out_ready   (umi_out_ready),
      .level           (level),
      .full            (full),
      .empty           (empty)
   );

   always #5 clk = ~clk;

   function automatic umi_packet_t rand_pkt();
      umi_packet_t p;
      for (int w = 0; w < UMI_DW / 32; w++) p.data[w*32 +: 32] = $urandom();
      p.srcaddr = {$urandom(), $urandom()};
      p.dstaddr = {$urandom(), $urandom()};
      p.cmd     = $urandom();
      return p;
   endfunction

   function automatic umi_packet_t out_pkt();
      return {umi_out_data, umi_out_srcaddr, umi_out_dstaddr, umi_out_cmd};
   endfunction

   task automatic drive_in(input logic v, input umi_packet_t p);
      umi_in_valid   = v;
      umi_in_cmd     = p.cmd;
      umi_in_dstaddr = p.dstaddr;
      umi_in_srcaddr = p.srcaddr;
      umi_in_data    = p.data;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      umi_out_ready = 1'b0;
      drive_in(1'b0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (empty !== 1'b1 || full !== 1'b0 || level !== 3'd0 || umi_in_ready !== 1'b1 || umi_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: empty=%b full=%b level=%0d in_ready=%b out_valid=%b, expected 1 0 0 1 0",
                  empty, full, level, umi_in_ready, umi_out_valid);
      end
      tests_run++;
      if (out_pkt() !== umi_packet_t'('0)) begin
         tests_failed++;
         $display("FAIL reset_payload: got %h expected 0", out_pkt());
      end
      #1 nreset = 1'b1;
      next_cycle();
   endtask

   task automatic test_single();
      umi_packet_t p;
      logic exp_pre;
      p = '0;
      p.cmd  = 32'h5;
      p.data = 256'hA5;
`ifdef UMI_ELASTIC_FIFO_BYPASS_EN
      exp_pre = 1'b1;
`else
      exp_pre = 1'b0;
`endif
      umi_out_ready = 1'b1;
      drive_in(1'b1, p);
      @(negedge clk);
      tests_run++;
      if (umi_out_valid !== exp_pre) begin
         tests_failed++;
         $display("FAIL single_latency_pre: out_valid=%b expected %b", umi_out_valid, exp_pre);
      end
`ifdef UMI_ELASTIC_FIFO_BYPASS_EN
      tests_run++;
      if (out_pkt() !== p) begin
         tests_failed++;
         $display("FAIL single_bypass_payload: got %h expected %h", out_pkt(), p);
      end
      next_cycle();
      drive_in(1'b0, '0);
      @(negedge clk);
      tests_run++;
      if (level !== 3'd0 || umi_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_bypass_nostore: level=%0d out_valid=%b expected 0 0", level, umi_out_valid);
      end
`else
      next_cycle();
      drive_in(1'b0, '0);
      @(negedge clk);
      tests_run++;
      if (umi_out_valid !== 1'b1 || out_pkt() !== p) begin
         tests_failed++;
         $display("FAIL single_payload: valid=%b got %h expected 1 %h", umi_out_valid, out_pkt(), p);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (empty !== 1'b1 || level !== 3'd0) begin
         tests_failed++;
         $display("FAIL single_drained: empty=%b level=%0d expected 1 0", empty, level);
      end
`endif
      next_cycle();
   endtask

   task automatic test_fill();
      umi_packet_t p;
      umi_out_ready = 1'b0;
      sb.delete();
      for (int i = 0; i < 6; i++) begin
         p = rand_pkt();
         drive_in(1'b1, p);
         @(negedge clk);
         tests_run++;
         if (umi_in_ready !== (i < DEPTH)) begin
            tests_failed++;
            $display("FAIL fill_in_ready[%0d]: got %b expected %b", i, umi_in_ready, (i < DEPTH));
         end
         if (umi_in_valid && umi_in_ready) sb.push_back(p);
         next_cycle();
      end
      drive_in(1'b0, '0);
      @(negedge clk);
      tests_run++;
      if (full !== 1'b1 || level !== 3'd4 || sb.size() != 4) begin
         tests_failed++;
         $display("FAIL fill_full: full=%b level=%0d accepted=%0d expected 1 4 4", full, level, sb.size());
      end
      next_cycle();
   endtask

   task automatic test_full_pop();
      umi_packet_t exp;
      drive_in(1'b1, rand_pkt());
      umi_out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (umi_in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pop_no_push: in_ready=%b expected 0", umi_in_ready);
      end
      exp = sb.pop_front();
      tests_run++;
      if (umi_out_valid !== 1'b1 || out_pkt() !== exp) begin
         tests_failed++;
         $display("FAIL full_pop_head: valid=%b got %h expected %h", umi_out_valid, out_pkt(), exp);
      end
      next_cycle();
      drive_in(1'b0, '0);
      umi_out_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (level !== 3'd3 || full !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pop_level: level=%0d full=%b expected 3 0", level, full);
      end
      // one more pop to reach level 2
      umi_out_ready = 1'b1;
      exp = sb.pop_front();
      tests_run++;
      if (out_pkt() !== exp) begin
         tests_failed++;
         $display("FAIL full_pop_head2: got %h expected %h", out_pkt(), exp);
      end
      next_cycle();
      umi_out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      umi_packet_t p, exp;
      int guard;
      for (int i = 0; i < 20; i++) begin
         p = rand_pkt();
         drive_in(1'b1, p);
         umi_out_ready = 1'b1;
         @(negedge clk);
         tests_run++;
         if (level !== 3'd2 || umi_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_level[%0d]: level=%0d in_ready=%b expected 2 1", i, level, umi_in_ready);
         end
         sb.push_back(p);
         exp = sb.pop_front();
         tests_run++;
         if (umi_out_valid !== 1'b1 || out_pkt() !== exp) begin
            tests_failed++;
            $display("FAIL b2b_order[%0d]: valid=%b got %h expected %h", i, umi_out_valid, out_pkt(), exp);
         end
         next_cycle();
      end
      drive_in(1'b0, '0);
      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(negedge clk);
         if (umi_out_valid) begin
            exp = sb.pop_front();
            tests_run++;
            if (out_pkt() !== exp) begin
               tests_failed++;
               $display("FAIL b2b_drain: got %h expected %h", out_pkt(), exp);
            end
         end
         guard++;
         next_cycle();
      end
      @(negedge clk);
      tests_run++;
      if (sb.size() != 0 || empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_drain_done: left=%0d empty=%b expected 0 1", sb.size(), empty);
      end
      next_cycle();
      umi_out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      umi_packet_t p;
      umi_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_in(1'b1, rand_pkt());
         next_cycle();
      end
      drive_in(1'b0, '0);
      @(negedge clk);
      tests_run++;
      if (level !== 3'd3) begin
         tests_failed++;
         $display("FAIL rstmid_level: level=%0d expected 3", level);
      end
      next_cycle();
      #2 nreset = 1'b0;
      #1;
      tests_run++;
      if (empty !== 1'b1 || umi_out_valid !== 1'b0 || level !== 3'd0) begin
         tests_failed++;
         $display("FAIL rstmid_async: empty=%b out_valid=%b level=%0d expected 1 0 0", empty, umi_out_valid, level);
      end
      nreset = 1'b1;
      sb.delete();
      next_cycle();
      p = rand_pkt();
      drive_in(1'b1, p);
      next_cycle();
      drive_in(1'b0, '0);
      umi_out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (umi_out_valid !== 1'b1 || out_pkt() !== p || level !== 3'd1) begin
         tests_failed++;
         $display("FAIL rstmid_first: valid=%b level=%0d got %h expected %h", umi_out_valid, level, out_pkt(), p);
      end
      next_cycle();
      umi_out_ready = 1'b0;
   endtask

   task automatic test_random();
      umi_packet_t p, exp;
      int sent, rcvd, cycles;
      sent = 0; rcvd = 0; cycles = 0;
      sb.delete();
      p = rand_pkt();
      while (rcvd < 10000 && cycles < 60000) begin
         drive_in((sent < 10000) && ($urandom_range(0, 3) != 0), p);
         umi_out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (umi_in_valid && umi_in_ready) begin
            sb.push_back(p);
            sent++;
            p = rand_pkt();
         end
         if (umi_out_valid && umi_out_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL rand_dup: pop with empty scoreboard, got %h", out_pkt());
            end else begin
               exp = sb.pop_front();
               if (out_pkt() !== exp) begin
                  tests_failed++;
                  $display("FAIL rand_order[%0d]: got %h expected %h", rcvd, out_pkt(), exp);
               end
            end
            rcvd++;
         end
         cycles++;
         next_cycle();
      end
      drive_in(1'b0, '0);
      umi_out_ready = 1'b0;
      tests_run++;
      if (rcvd != 10000 || sent != 10000 || sb.size() != 0) begin
         tests_failed++;
         $display("FAIL rand_count: sent=%0d rcvd=%0d left=%0d expected 10000 10000 0", sent, rcvd, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_pop();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/umi_elastic_fifo.md
UMI_ELASTIC_FIFO -- requirements
Module: umi_elastic_fifo

Interface
REQ-001 SHALL have parameter DW, default 256, the UMI data width in bits.
REQ-002 SHALL have parameter AW, default 64, the srcaddr/dstaddr width in bits.
REQ-003 SHALL have parameter CW, default 32, the cmd width in bits.
REQ-004 SHALL have parameter DEPTH, default 4, the entry count; a power of two, at least 2.
REQ-005 SHALL have one clock and an asynchronous active-low reset, as listed in REQ-006 and REQ-007.
REQ-006 SHALL have port clk, input, 1 bit: sole clock; all state on its rising edge.
REQ-007 SHALL have port nreset, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port umi_in_valid, input, 1 bit: upstream packet valid.
REQ-009 SHALL have ports umi_in_cmd (CW), umi_in_dstaddr (AW), umi_in_srcaddr (AW) and umi_in_data (DW), all inputs: the upstream packet fields.
REQ-010 SHALL have port umi_in_ready, output, 1 bit: the FIFO accepts a packet.
REQ-011 SHALL have port umi_out_valid, output, 1 bit: a head packet is available.
REQ-012 SHALL have ports umi_out_cmd (CW), umi_out_dstaddr (AW), umi_out_srcaddr (AW) and umi_out_data (DW), all outputs: the head packet fields.
REQ-013 SHALL have port umi_out_ready, input, 1 bit: downstream accepts the head packet.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1 bits: the number of stored entries.
REQ-015 SHALL have ports full and empty, outputs, 1 bit each: the occupancy flags.

Function
REQ-016 A push SHALL occur on a cycle with umi_in_valid and umi_in_ready both high; a pop SHALL occur on a cycle with umi_out_valid and umi_out_ready both high.
REQ-017 umi_in_ready SHALL equal !full, combinationally from registered state only, with no dependence on umi_out_ready.
REQ-018 umi_out_valid SHALL equal !empty; the head entry SHALL remain stable until popped.
REQ-019 All umi_out_* payload fields SHALL be driven to zero whenever umi_out_valid is low.
REQ-020 Latency without bypass SHALL be one cycle: a packet pushed at edge N is presented at umi_out after edge N.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full is asserted when the pointers differ only in the MSB, and empty when they are equal.
REQ-022 level SHALL equal wr_ptr-wr_ptr's counterpart difference, i.e. wr_ptr minus rd_ptr modulo 2*DEPTH, and SHALL range 0..DEPTH.
REQ-023 A simultaneous push and pop SHALL leave level unchanged and preserve packet order.
REQ-024 When full, the FIFO SHALL NOT accept a push even if a pop occurs in the same cycle.
REQ-025 When empty, a pop SHALL NOT occur and the pointers SHALL be unchanged.
REQ-026 Packets SHALL be delivered in FIFO order with all CW+AW+AW+DW bits preserved bit-exactly.

Reset
REQ-027 While nreset is low: pointers SHALL be 0, level 0, empty 1, full 0, umi_in_ready 1, umi_out_valid 0, and payload outputs 0.
REQ-028 Assertion of reset mid-operation SHALL discard all stored entries immediately, without waiting for a clock.
REQ-029 Storage contents SHALL NOT be reset; only pointers and flags are reset.

Configuration
REQ-030 Macro UMI_ELASTIC_FIFO_BYPASS_EN SHALL select the bypass behaviour; when it is undefined, REQ-020 holds.
REQ-031 With UMI_ELASTIC_FIFO_BYPASS_EN defined and the FIFO empty, umi_out_valid SHALL follow umi_in_valid and umi_out_* SHALL follow umi_in_* combinationally.
REQ-032 In that bypass case, if umi_out_ready is high the packet SHALL NOT be written and level SHALL stay 0; otherwise it SHALL be written normally.
REQ-033 With bypass defined and the FIFO not empty, behaviour SHALL be identical to the non-bypass build.

Structure
REQ-034 Shared package sb_umi_pkg SHALL hold the default DW/AW/CW constants and a packed packet typedef built from these constants.
REQ-035 The packed packet typedef SHALL order its fields cmd, dstaddr, srcaddr, data, with cmd in the LSBs and data in the MSBs.
REQ-036 Storage SHALL be the sub-module umi_elastic_fifo_mem: a DEPTH x packet register array with one write port and one asynchronous read port.

Verification
REQ-037 Reset release, then 1 push (cmd=0x5, data=0xA5) with out_ready=1: umi_out_valid rises 1 cycle later (0 cycles with bypass), and the payload matches.
REQ-038 DEPTH=4, out_ready=0, 6 push attempts: 4 accepted; full=1 and level=4; in_ready=0 on attempts 5 and 6.
REQ-039 Full FIFO with in_valid=1 and out_ready=1 held 1 cycle: 1 pop, no push, level=3.
REQ-040 Level 2 with push and pop on the same cycle for 20 cycles: level stays 2; 20 packets exit in order across 2.5 pointer wraps.
REQ-041 Level 3, then nreset pulsed low mid-cycle: immediately empty=1 and out_valid=0; the next push is delivered as the first packet.
REQ-042 Randomized valid/ready for 10k packets with a scoreboard: no loss, no duplication, and exact order.
